// File: rtl/lif_synapse_pkg.sv
// Shared neuron package: default parameter values for the LIF synapse/neuron
// blocks and a small width helper used when sizing indices and counters.
package lif_synapse_pkg;

   localparam int unsigned NInDefault         = 3;
   localparam int unsigned WDefault           = 8;
   localparam int unsigned DecayShiftDefault  = 2;
   localparam int unsigned DecayPeriodDefault = 4;
   localparam int unsigned WeightInitDefault  = 16;

   // Bits needed to index 0..n-1, never less than one so ports stay legal for n=1.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lif_synapse_spike_edge_detect.sv
// spike_edge_detect: holds the previous-spike register and emits a one-cycle
// event pulse for every input that rose since the last enabled cycle.
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset (previous-spike register -> 0)
//   ena       - when low, the previous-spike register holds and no events fire
//   spike_in  - presynaptic spike levels
//   spike_evt - per-input rising-edge events (combinational)
module spike_edge_detect #(
   parameter int unsigned N_IN = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [N_IN-1:0] spike_in,
   output logic [N_IN-1:0] spike_evt
);

   logic [N_IN-1:0] prev_q, prev_d;

   always_comb begin
      prev_d    = ena ? spike_in : prev_q;
      spike_evt = ena ? (spike_in & ~prev_q) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/lif_synapse.sv
// lif_synapse: leaky-integrating synaptic current. Each rising spike on an
// input adds that input's weight to isyn; every DECAY_PERIOD cycles isyn loses
// isyn >> DECAY_SHIFT. The sum saturates at 2^W-1 and flags sat for one cycle.
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   ena      - enable; low holds isyn, tick counter and spike history
//   spike_in - presynaptic spike levels
//   wr_en    - weight write strobe (honoured regardless of ena)
//   wr_addr  - weight index; out-of-range writes are dropped
//   wr_data  - unsigned weight value
//   isyn     - registered synaptic current
//   sat      - registered pulse, high for the cycle after a clipped update
module lif_synapse
   import lif_synapse_pkg::*;
#(
   parameter int unsigned N_IN         = NInDefault,
   parameter int unsigned W            = WDefault,
   parameter int unsigned DECAY_SHIFT  = DecayShiftDefault,
   parameter int unsigned DECAY_PERIOD = DecayPeriodDefault,
   parameter int unsigned WEIGHT_INIT  = WeightInitDefault
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [N_IN-1:0]           spike_in,
   input  logic                      wr_en,
   input  logic [idx_width(N_IN)-1:0] wr_addr,
   input  logic [W-1:0]              wr_data,
   output logic [W-1:0]              isyn,
   output logic                      sat
);

   localparam int unsigned AW = idx_width(N_IN);
   localparam int unsigned TW = idx_width(DECAY_PERIOD);
   // Wide enough for a full-scale current plus every weight at full scale.
   localparam int unsigned SW = W + AW + 1;

   // ---------------------------------------------------------------- events
   logic [N_IN-1:0] spike_evt;

   spike_edge_detect #(
      .N_IN (N_IN)
   ) u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .spike_in  (spike_in),
      .spike_evt (spike_evt)
   );

   // ---------------------------------------------------------- weight file
   logic [W-1:0] weight_q [N_IN];
   logic [W-1:0] weight_d [N_IN];
   logic         wr_ok;

   always_comb begin
      wr_ok = wr_en && (32'(wr_addr) < N_IN);
      for (int i = 0; i < N_IN; i++) begin
         weight_d[i] = weight_q[i];
         if (wr_ok && (32'(wr_addr) == i)) begin
            weight_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            weight_q[i] <= W'(WEIGHT_INIT);
         end
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            weight_q[i] <= weight_d[i];
         end
      end
   end

   // ---------------------------------------------------------- tick counter
   logic [TW-1:0] tick_q, tick_d;
   logic          tick_last;

   always_comb begin
      tick_last = (tick_q == TW'(DECAY_PERIOD - 1));
      tick_d    = tick_q;
      if (ena) begin
         tick_d = tick_last ? '0 : tick_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_d;
      end
   end

   // ------------------------------------------------- accumulate/saturate
   logic [W-1:0]  isyn_q, isyn_d;
   logic          sat_q, sat_d;
   logic [W-1:0]  decayed;
   logic [SW-1:0] total;
   logic          over;

   always_comb begin
      // Decay first, then add events, so a same-cycle event is never decayed.
      decayed = tick_last ? (isyn_q - (isyn_q >> DECAY_SHIFT)) : isyn_q;
      total   = SW'(decayed);
      for (int i = 0; i < N_IN; i++) begin
         if (spike_evt[i]) begin
            total = total + SW'(weight_q[i]);
         end
      end
      over   = (total > SW'({W{1'b1}}));
      isyn_d = isyn_q;
      sat_d  = 1'b0;
      if (ena) begin
         isyn_d = over ? {W{1'b1}} : total[W-1:0];
         sat_d  = over;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isyn_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         isyn_q <= isyn_d;
         sat_q  <= sat_d;
      end
   end

   assign isyn = isyn_q;
   assign sat  = sat_q;

endmodule

// File: tb/tb_lif_synapse.sv
module tb_lif_synapse;

   localparam int NIn = 3;
   localparam int DP  = 4;
   localparam int DS  = 2;
   localparam int MaxI = 255;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [2:0] spike_in;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] isyn;
   logic       sat;

   int n_cmp  = 0;
   int n_fail = 0;

   lif_synapse dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .spike_in (spike_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .isyn     (isyn),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------ behavioural reference
   int         m_isyn = 0;
   int         m_sat  = 0;
   int         m_tick = 0;
   bit [2:0]   m_prev = '0;
   int         m_w [NIn] = '{16, 16, 16};
   int         m_next;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_isyn = 0;
         m_sat  = 0;
         m_tick = 0;
         m_prev = '0;
         for (int i = 0; i < NIn; i++) m_w[i] = 16;
      end else begin
         if (ena) begin
            m_next = m_isyn;
            if (m_tick == DP - 1) m_next = m_isyn - (m_isyn / (1 << DS));
            for (int i = 0; i < NIn; i++)
               if (spike_in[i] && !m_prev[i]) m_next += m_w[i];
            m_sat  = (m_next > MaxI) ? 1 : 0;
            m_isyn = (m_next > MaxI) ? MaxI : m_next;
            m_tick = (m_tick + 1) % DP;
            m_prev = spike_in;
         end else begin
            m_sat = 0;
         end
         // Writes land after the event sum, so a same-cycle event sees the old weight.
         if (wr_en && int'(wr_addr) < NIn) m_w[wr_addr] = int'(wr_data);
      end
   end

   // Outputs are registered: compare on every falling edge.
   always @(negedge clk) begin
      check("isyn_model", int'(isyn), m_isyn);
      check("sat_model", int'(sat), m_sat);
   end

   // --------------------------------------------------------------- stimulus
   task automatic idle_inputs();
      ena      = 1'b1;
      spike_in = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int seq[$];
   int e32[8] = '{16, 12, 9, 7, 6, 5, 4, 3};
   int ups, stepv, last, k;

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("reset_isyn", int'(isyn), 0);
      check("reset_sat", int'(sat), 0);
      rst_n = 1'b1;

      // Single event decays through the shift sequence to a stuck residual.
      do_reset();
      spike_in = 3'b001;
      @(negedge clk);
      spike_in = '0;
      seq.delete();
      seq.push_back(int'(isyn));
      repeat (40) begin
         @(negedge clk);
         if (int'(isyn) != seq[$]) seq.push_back(int'(isyn));
      end
      check("decay_len", seq.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < seq.size()) check($sformatf("decay_seq[%0d]", i), seq[i], e32[i]);
      check("decay_residual", int'(isyn), 3);

      // Held level counts once.
      do_reset();
      spike_in = 3'b010;
      ups = 0; stepv = 0; last = int'(isyn);
      repeat (14) begin
         @(negedge clk);
         if (int'(isyn) > last) begin
            ups++;
            stepv = int'(isyn) - last;
         end
         last = int'(isyn);
         if (ups > 0 && k == 0) k = 0;
      end
      spike_in = '0;
      check("held_ups", ups, 1);
      check("held_step", stepv, 16);

      // Saturation.
      do_reset();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd200;
      @(negedge clk);
      wr_addr = 2'd1; wr_data = 8'd100;
      @(negedge clk);
      wr_en = 1'b0;
      spike_in = 3'b011;
      @(negedge clk);
      check("sat_isyn", int'(isyn), 255);
      check("sat_pulse", int'(sat), 1);
      spike_in = '0;
      @(negedge clk);
      check("sat_clear", int'(sat), 0);

      // Write collision uses the old weight; the new one applies next time.
      do_reset();
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd50; spike_in = 3'b100;
      @(negedge clk);
      wr_en = 1'b0; spike_in = '0;
      check("coll_old_w", int'(isyn), 16);
      repeat (40) @(negedge clk);
      check("coll_settle", int'(isyn), 3);
      spike_in = 3'b100;
      @(negedge clk);
      spike_in = '0;
      check("coll_new_w", int'(isyn), 53);

      // Invalid address is ignored.
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'd99;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (4) @(negedge clk);

      // Enable hold.
      do_reset();
      spike_in = 3'b001;
      @(negedge clk);
      spike_in = '0;
      k = 0;
      while (int'(isyn) != 12 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("hold_reach12", int'(isyn), 12);
      ena = 1'b0;
      for (int i = 0; i < 8; i++) begin
         spike_in = 3'($urandom);
         @(negedge clk);
         check("hold_isyn", int'(isyn), 12);
         check("hold_sat", int'(sat), 0);
      end
      spike_in = '0;
      ena = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("resume_pre", int'(isyn), 12);
      end
      @(negedge clk);
      check("resume_tick", int'(isyn), 9);

      // Mid-operation asynchronous reset restores weights.
      do_reset();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd200;
      @(negedge clk);
      wr_en = 1'b0; spike_in = 3'b001;
      @(negedge clk);
      check("pre_rst_isyn", int'(isyn), 200);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_isyn", int'(isyn), 0);
      check("async_rst_sat", int'(sat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_w0", int'(isyn), 16);
      spike_in = '0;

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         spike_in = 3'($urandom & $urandom);
         ena      = ($urandom_range(0, 9) != 0);
         wr_en    = ($urandom_range(0, 7) == 0);
         wr_addr  = 2'($urandom_range(0, 3));
         wr_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lif_synapse.md
LIF_SYNAPSE -- requirements
Module: lif_synapse

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of presynaptic spike inputs.
REQ-002 SHALL have parameter W, default 8, width of weights and of the current output.
REQ-003 SHALL have parameter DECAY_SHIFT, default 2, decay amount is isyn >> DECAY_SHIFT.
REQ-004 SHALL have parameter DECAY_PERIOD, default 4, clock cycles between decay ticks (>=1).
REQ-005 SHALL have parameter WEIGHT_INIT, default 16, reset value of every weight.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ena, input, 1, active-high enable.
REQ-009 SHALL have port spike_in, input, N_IN, presynaptic spike levels, synchronous to clk.
REQ-010 SHALL have port wr_en, input, 1, weight write strobe.
REQ-011 SHALL have port wr_addr, input, clog2(N_IN), index of the weight to write.
REQ-012 SHALL have port wr_data, input, W, unsigned weight value.
REQ-013 SHALL have port isyn, output, W, registered unsigned synaptic current that drives the downstream neuron Isyn input.
REQ-014 SHALL have port sat, output, 1, registered one-cycle pulse set when the current update clipped.

Function
REQ-015 SHALL detect a spike event on input i only when spike_in[i]=1 and its registered previous value is 0, so a held-high level counts once.
REQ-016 SHALL advance a tick counter 0..DECAY_PERIOD-1 with wrap; a decay tick occurs on the cycle the counter equals DECAY_PERIOD-1.
REQ-017 SHALL form decayed = isyn - (isyn >> DECAY_SHIFT) on tick cycles, decayed = isyn otherwise.
REQ-018 SHALL form next = decayed + the sum of weights of all inputs with an event this cycle, computed at width W+clog2(N_IN)+1 with no intermediate overflow.
REQ-019 SHALL load isyn with min(next, 2^W-1) and drive sat=1 for exactly that cycle when next > 2^W-1, else sat=0.
REQ-020 SHALL make an event sampled at edge k visible on isyn after edge k (latency 1 cycle).
REQ-021 SHALL apply decay before event addition when both occur in the same cycle.
REQ-022 SHALL, on wr_en=1, write wr_data to weight[wr_addr] at the clock edge; an event on the same index in the same cycle uses the old weight.
REQ-023 SHALL ignore writes with wr_addr >= N_IN.
REQ-024 SHALL accept weight writes regardless of ena.
REQ-025 SHALL, when ena=0, hold isyn, the tick counter and the previous-spike register, and force sat=0.
REQ-026 SHALL leave a residual isyn below 2^DECAY_SHIFT undecayed, since the shift yields 0; no forced zeroing.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force isyn=0, sat=0, tick counter=0, previous-spike register=0, all weights=WEIGHT_INIT.
REQ-028 SHALL resume normal operation on the first rising edge after rst_n deasserts; a spike_in already high at that edge counts as an event.

Structure
REQ-029 SHALL place the default values of W, N_IN, DECAY_SHIFT, DECAY_PERIOD and WEIGHT_INIT in the shared neuron package used by the LIF neuron.
REQ-030 SHALL contain one sub-module, spike_edge_detect, holding the previous-spike register and emitting per-input event pulses.
REQ-031 SHALL keep the weight register file, tick counter and accumulator/saturation inline in lif_synapse.

Verification
REQ-032 Single event: defaults, one spike on input 0, no further spikes -> isyn sequence on ticks 16,12,9,7,6,5,4,3, then holds 3.
REQ-033 Held level: spike_in[1] high for 10 cycles -> exactly one +16 step, no further increments.
REQ-034 Saturation: weights 200 and 100 written to inputs 0 and 1, simultaneous rising spikes from isyn=0 -> isyn=255, sat high one cycle.
REQ-035 Write collision: wr_en with wr_addr=2, wr_data=50 in the same cycle as an event on input 2 -> isyn +16; the next event on input 2 adds +50.
REQ-036 Enable hold: ena=0 for 8 cycles with isyn=12 and spikes toggling -> isyn stays 12, sat=0; decay resumes from the held counter.
REQ-037 Mid-operation reset: rst_n low asynchronously with isyn=200 and weights modified -> isyn=0 immediately, weights read back as 16 via event response.
